exe_module: RTL and testbench

Execute stage of the ARM-subset five-stage pipeline, sitting directly upstream of the memory stage. It resolves forwarded operands, builds the second operand (Val2), runs the ALU, and computes the branch target. It maintains the NZCV status register and latches results into the EXE/MEM pipeline register consumed by the memory stage.

---
 rtl/exe_module.sv | 191 +++++++++++++++++++
 tb/tb_exe_module.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/exe_module.sv
`default_nettype none
// ============================================================================
// Module   : exe_module
// Purpose  : ARM-subset execute stage: forwarding, Val2 generation, ALU,
//            NZCV status register, branch target and EXE/MEM register.
// Revision : 1.0 - initial release
// ============================================================================
module exe_module (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        wb_en,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [3:0]  exe_cmd,
    input  logic        s_update,
    input  logic        imm,
    input  logic [11:0] shift_operand,
    input  logic [23:0] signed_imm_24,
    input  logic [3:0]  dest,
    input  logic [31:0] pc,
    input  logic [31:0] val_rn,
    input  logic [31:0] val_rm,
    input  logic [1:0]  sel_src1,
    input  logic [1:0]  sel_src2,
    input  logic [31:0] mem_fwd_val,
    input  logic [31:0] wb_fwd_val,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic        mem_w_en_out,
    output logic [3:0]  dest_out,
    output logic [31:0] alu_res_out,
    output logic [31:0] val_rm_out,
    output logic [3:0]  status_out,
    output logic [31:0] branch_address
);

    localparam logic [3:0] c_CMD_MOV = 4'b0001;
    localparam logic [3:0] c_CMD_MVN = 4'b1001;
    localparam logic [3:0] c_CMD_ADD = 4'b0010;
    localparam logic [3:0] c_CMD_ADC = 4'b0011;
    localparam logic [3:0] c_CMD_SUB = 4'b0100;
    localparam logic [3:0] c_CMD_SBC = 4'b0101;
    localparam logic [3:0] c_CMD_AND = 4'b0110;
    localparam logic [3:0] c_CMD_ORR = 4'b0111;
    localparam logic [3:0] c_CMD_EOR = 4'b1000;

    logic        wb_en_q, wb_en_d;
    logic        mem_r_en_q, mem_r_en_d;
    logic        mem_w_en_q, mem_w_en_d;
    logic [3:0]  dest_q, dest_d;
    logic [31:0] alu_res_q, alu_res_d;
    logic [31:0] val_rm_q, val_rm_d;
    logic [3:0]  status_q, status_d;

    logic [31:0] w_op1;
    logic [31:0] w_rm_f;
    logic [31:0] w_val2;
    logic [31:0] w_imm_base;
    logic [63:0] w_imm_rot;
    logic [63:0] w_rm_rot;
    logic [4:0]  w_shamt;
    logic [32:0] w_sum;
    logic [31:0] w_res;
    logic        w_c;
    logic        w_v;
    logic        w_cmd_valid;
    logic        w_c_in;

    // Select 3 falls back to the register file just like select 0.
    always_comb begin
        w_op1 = val_rn;
        case (sel_src1)
            2'd1:    w_op1 = mem_fwd_val;
            2'd2:    w_op1 = wb_fwd_val;
            default: w_op1 = val_rn;
        endcase
        w_rm_f = val_rm;
        case (sel_src2)
            2'd1:    w_rm_f = mem_fwd_val;
            2'd2:    w_rm_f = wb_fwd_val;
            default: w_rm_f = val_rm;
        endcase
    end

    // Rotates use a doubled word so a zero amount needs no special case.
    always_comb begin
        w_shamt    = shift_operand[11:7];
        w_imm_base = {24'b0, shift_operand[7:0]};
        w_imm_rot  = {w_imm_base, w_imm_base} >> {shift_operand[11:8], 1'b0};
        w_rm_rot   = {w_rm_f, w_rm_f} >> w_shamt;
        w_val2     = w_rm_f;
        if (mem_r_en || mem_w_en) begin
            w_val2 = {20'b0, shift_operand};
        end else if (imm) begin
            w_val2 = w_imm_rot[31:0];
        end else begin
            case (shift_operand[6:5])
                2'b00:   w_val2 = w_rm_f << w_shamt;
                2'b01:   w_val2 = w_rm_f >> w_shamt;
                2'b10:   w_val2 = $signed(w_rm_f) >>> w_shamt;
                default: w_val2 = w_rm_rot[31:0];
            endcase
        end
    end

    assign w_c_in = status_q[1];

    // Subtraction is op1 + ~val2 + carry, so C comes out as inverted borrow.
    always_comb begin
        w_sum       = 33'b0;
        w_res       = 32'b0;
        w_c         = status_q[1];
        w_v         = status_q[0];
        w_cmd_valid = 1'b1;
        case (exe_cmd)
            c_CMD_MOV: w_res = w_val2;
            c_CMD_MVN: w_res = ~w_val2;
            c_CMD_ADD, c_CMD_ADC: begin
                w_sum = {1'b0, w_op1} + {1'b0, w_val2}
                      + {32'b0, (exe_cmd == c_CMD_ADC) ? w_c_in : 1'b0};
                w_res = w_sum[31:0];
                w_c   = w_sum[32];
                w_v   = (w_op1[31] == w_val2[31]) && (w_res[31] != w_op1[31]);
            end
            c_CMD_SUB, c_CMD_SBC: begin
                w_sum = {1'b0, w_op1} + {1'b0, ~w_val2}
                      + {32'b0, (exe_cmd == c_CMD_SBC) ? w_c_in : 1'b1};
                w_res = w_sum[31:0];
                w_c   = w_sum[32];
                w_v   = (w_op1[31] != w_val2[31]) && (w_res[31] != w_op1[31]);
            end
            c_CMD_AND: w_res = w_op1 & w_val2;
            c_CMD_ORR: w_res = w_op1 | w_val2;
            c_CMD_EOR: w_res = w_op1 ^ w_val2;
            default:   w_cmd_valid = 1'b0;
        endcase
    end

    always_comb begin
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        mem_w_en_d = mem_w_en_q;
        dest_d     = dest_q;
        alu_res_d  = alu_res_q;
        val_rm_d   = val_rm_q;
        status_d   = status_q;
        if (!freeze) begin
            wb_en_d    = wb_en;
            mem_r_en_d = mem_r_en;
            mem_w_en_d = mem_w_en;
            dest_d     = dest;
            alu_res_d  = w_res;
            val_rm_d   = w_rm_f;
            if (s_update && w_cmd_valid) begin
                status_d = {w_res[31], (w_res == 32'b0), w_c, w_v};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            dest_q     <= 4'b0;
            alu_res_q  <= 32'b0;
            val_rm_q   <= 32'b0;
            status_q   <= 4'b0;
        end else begin
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            mem_w_en_q <= mem_w_en_d;
            dest_q     <= dest_d;
            alu_res_q  <= alu_res_d;
            val_rm_q   <= val_rm_d;
            status_q   <= status_d;
        end
    end

    assign wb_en_out      = wb_en_q;
    assign mem_r_en_out   = mem_r_en_q;
    assign mem_w_en_out   = mem_w_en_q;
    assign dest_out       = dest_q;
    assign alu_res_out    = alu_res_q;
    assign val_rm_out     = val_rm_q;
    assign status_out     = status_q;
    assign branch_address = pc + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_exe_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_module
// Purpose  : Self-checking bench for exe_module (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_module;

    logic        clk = 1'b0;
    logic        rst, freeze, wb_en, mem_r_en, mem_w_en, s_update, imm;
    logic [3:0]  exe_cmd, dest;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [31:0] pc, val_rn, val_rm, mem_fwd_val, wb_fwd_val;
    logic [1:0]  sel_src1, sel_src2;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out;
    logic [3:0]  dest_out, status_out;
    logic [31:0] alu_res_out, val_rm_out, branch_address;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exe_module dut (
        .clk(clk), .rst(rst), .freeze(freeze), .wb_en(wb_en),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .exe_cmd(exe_cmd),
        .s_update(s_update), .imm(imm), .shift_operand(shift_operand),
        .signed_imm_24(signed_imm_24), .dest(dest), .pc(pc),
        .val_rn(val_rn), .val_rm(val_rm), .sel_src1(sel_src1),
        .sel_src2(sel_src2), .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
        .mem_w_en_out(mem_w_en_out), .dest_out(dest_out),
        .alu_res_out(alu_res_out), .val_rm_out(val_rm_out),
        .status_out(status_out), .branch_address(branch_address)
    );

    typedef struct {
        logic [1:0]  s1, s2;
        logic [31:0] rn, rm, mf, wf;
        logic [3:0]  cmd;
        logic        s, im, mr, mw, wb;
        logic [11:0] so;
        logic [31:0] e_res, e_rm;
        logic [3:0]  e_st;
    } vec_t;

    typedef struct {
        logic [31:0] res, rm;
        logic [3:0]  st, dst;
        logic [2:0]  ctl;
    } exp_t;

    localparam int c_NVEC = 19;
    vec_t tbl [c_NVEC];
    exp_t sb [$];

    function automatic vec_t mk(logic [1:0] s1, logic [1:0] s2, logic [31:0] rn,
                                logic [31:0] rm, logic [31:0] mf, logic [31:0] wf,
                                logic [3:0] cmd, logic s, logic im, logic mr,
                                logic mw, logic wb, logic [11:0] so,
                                logic [31:0] e_res, logic [31:0] e_rm,
                                logic [3:0] e_st);
        vec_t v;
        v.s1 = s1; v.s2 = s2; v.rn = rn; v.rm = rm; v.mf = mf; v.wf = wf;
        v.cmd = cmd; v.s = s; v.im = im; v.mr = mr; v.mw = mw; v.wb = wb;
        v.so = so; v.e_res = e_res; v.e_rm = e_rm; v.e_st = e_st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic [3:0] d);
        sel_src1 = v.s1; sel_src2 = v.s2; val_rn = v.rn; val_rm = v.rm;
        mem_fwd_val = v.mf; wb_fwd_val = v.wf; exe_cmd = v.cmd;
        s_update = v.s; imm = v.im; mem_r_en = v.mr; mem_w_en = v.mw;
        wb_en = v.wb; shift_operand = v.so; dest = d;
    endtask

    task automatic chk_outs(input string tag, input exp_t e);
        chk({tag, ".res"}, alu_res_out, e.res);
        chk({tag, ".rm"}, val_rm_out, e.rm);
        chk({tag, ".nzcv"}, {28'b0, status_out}, {28'b0, e.st});
        chk({tag, ".dest"}, {28'b0, dest_out}, {28'b0, e.dst});
        chk({tag, ".ctl"}, {29'b0, wb_en_out, mem_r_en_out, mem_w_en_out},
            {29'b0, e.ctl});
    endtask

    initial begin
        exp_t e;
        vec_t v;
        //            s1 s2 rn            rm            mf     wf     cmd  s  im mr mw wb so      res           rm            nzcv
        tbl[0]  = mk(1, 0, 32'd99,       32'd5,        32'd10, 0,     4'h2, 0, 0, 0, 0, 1, 12'h000, 32'd15,       32'd5,        4'h0);
        tbl[1]  = mk(0, 0, 32'd3,        32'd5,        0,      0,     4'h4, 1, 0, 0, 0, 1, 12'h000, 32'hFFFFFFFE, 32'd5,        4'h8);
        tbl[2]  = mk(0, 0, 32'd5,        32'd5,        0,      0,     4'h4, 1, 0, 0, 0, 1, 12'h000, 32'd0,        32'd5,        4'h6);
        tbl[3]  = mk(0, 0, 32'h7FFFFFFF, 32'd1,        0,      0,     4'h2, 1, 0, 0, 0, 1, 12'h000, 32'h80000000, 32'd1,        4'h9);
        tbl[4]  = mk(0, 0, 32'd5,        32'd5,        0,      0,     4'h4, 1, 0, 0, 0, 1, 12'h000, 32'd0,        32'd5,        4'h6);
        tbl[5]  = mk(0, 0, 32'd0,        32'd0,        0,      0,     4'h3, 1, 0, 0, 0, 1, 12'h000, 32'd1,        32'd0,        4'h0);
        tbl[6]  = mk(0, 0, 32'd0,        32'd0,        0,      0,     4'h3, 0, 0, 0, 0, 1, 12'h000, 32'd0,        32'd0,        4'h0);
        tbl[7]  = mk(0, 0, 32'd5,        32'd3,        0,      0,     4'h5, 1, 0, 0, 0, 1, 12'h000, 32'd1,        32'd3,        4'h2);
        tbl[8]  = mk(0, 0, 32'd0,        32'h1234,     0,      0,     4'h1, 0, 1, 0, 0, 1, 12'h2FF, 32'hF000000F, 32'h1234,     4'h2);
        tbl[9]  = mk(0, 0, 32'd0,        32'h80000000, 0,      0,     4'h1, 1, 0, 0, 0, 1, 12'h240, 32'hF8000000, 32'h80000000, 4'hA);
        tbl[10] = mk(0, 0, 32'h1000,     32'hDEADBEEF, 0,      0,     4'h2, 0, 0, 0, 1, 0, 12'h804, 32'h1804,     32'hDEADBEEF, 4'hA);
        tbl[11] = mk(0, 0, 32'd0,        32'hF0,       0,      0,     4'h1, 0, 0, 0, 0, 1, 12'h220, 32'h0F,       32'hF0,       4'hA);
        tbl[12] = mk(0, 0, 32'hF0,       32'h0F,       0,      0,     4'h6, 1, 0, 0, 0, 1, 12'h000, 32'd0,        32'h0F,       4'h6);
        tbl[13] = mk(0, 0, 32'd0,        32'hFF,       0,      0,     4'h9, 1, 0, 0, 0, 1, 12'h400, 32'hFFFF00FF, 32'hFF,       4'hA);
        tbl[14] = mk(3, 2, 32'h00F,      32'h999,      0,      32'hF0, 4'h7, 0, 0, 0, 0, 1, 12'h000, 32'hFF,      32'hF0,       4'hA);
        tbl[15] = mk(2, 1, 32'h111,      32'h222,      32'h0F, 32'hFF, 4'h8, 0, 0, 0, 0, 1, 12'h000, 32'hF0,      32'h0F,       4'hA);
        tbl[16] = mk(0, 0, 32'd5,        32'd5,        0,      0,     4'h0, 1, 0, 0, 0, 1, 12'h000, 32'd0,        32'd5,        4'hA);
        tbl[17] = mk(0, 0, 32'd0,        32'd1,        0,      0,     4'h1, 1, 0, 0, 0, 1, 12'h0E0, 32'h80000000, 32'd1,        4'hA);
        tbl[18] = mk(0, 0, 32'h2000,     32'd7,        0,      0,     4'h2, 0, 1, 1, 0, 1, 12'hFFF, 32'h2FFF,     32'd7,        4'hA);

        rst = 1'b1; freeze = 1'b0; pc = 32'h0; signed_imm_24 = 24'h0;
        drive(tbl[0], 4'hF);
        repeat (2) @(posedge clk);
        #1;
        e = '{res: 0, rm: 0, st: 0, dst: 0, ctl: 0};
        chk_outs("reset", e);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < c_NVEC; i++) begin
            drive(tbl[i], i[3:0]);
            sb.push_back('{res: tbl[i].e_res, rm: tbl[i].e_rm, st: tbl[i].e_st,
                           dst: i[3:0], ctl: {tbl[i].wb, tbl[i].mr, tbl[i].mw}});
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk_outs($sformatf("vec%0d", i), e);
            end
            @(negedge clk);
        end

        // Freeze: ADD 1+2 is latched, then a flag-setting SUB is held off.
        v = mk(0, 0, 32'd1, 32'd2, 0, 0, 4'h2, 0, 0, 0, 0, 1, 12'h000, 0, 0, 0);
        drive(v, 4'h3);
        @(posedge clk); #1;
        e = '{res: 32'd3, rm: 32'd2, st: 4'hA, dst: 4'h3, ctl: 3'b100};
        chk_outs("frz_load", e);
        @(negedge clk);
        freeze = 1'b1;
        v = mk(0, 0, 32'd3, 32'd5, 0, 0, 4'h4, 1, 0, 0, 0, 0, 12'h000, 0, 0, 0);
        drive(v, 4'h9);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk_outs($sformatf("frz_hold%0d", k), e);
        end
        @(negedge clk);
        freeze = 1'b0;
        @(posedge clk); #1;
        e = '{res: 32'hFFFFFFFE, rm: 32'd5, st: 4'h8, dst: 4'h9, ctl: 3'b000};
        chk_outs("frz_release", e);

        // Reset mid-stream with freeze also high.
        @(negedge clk);
        rst = 1'b1; freeze = 1'b1;
        v = mk(0, 0, 32'd1, 32'd1, 0, 0, 4'h2, 1, 0, 1, 0, 1, 12'h000, 0, 0, 0);
        drive(v, 4'h7);
        @(posedge clk); #1;
        e = '{res: 0, rm: 0, st: 0, dst: 0, ctl: 0};
        chk_outs("rst_mid", e);
        @(negedge clk);
        rst = 1'b0; freeze = 1'b0;
        v = mk(0, 0, 32'd2, 32'd2, 0, 0, 4'h2, 0, 0, 0, 0, 1, 12'h000, 0, 0, 0);
        drive(v, 4'h5);
        @(posedge clk); #1;
        e = '{res: 32'd4, rm: 32'd2, st: 4'h0, dst: 4'h5, ctl: 3'b100};
        chk_outs("rst_after", e);

        // Branch target, including with freeze asserted.
        @(negedge clk);
        pc = 32'h100; signed_imm_24 = 24'hFFFFFE; freeze = 1'b1;
        #1 chk("br_neg", branch_address, 32'hF8);
        pc = 32'h40; signed_imm_24 = 24'h000010;
        #1 chk("br_pos", branch_address, 32'h80);
        freeze = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
